spi_regfile_peripheral: RTL
===========================

Name: spi_regfile_peripheral

Overview:
Parametrised SPI Mode-0 target giving an external controller read/write access to a bank of NUM_REGS registers of DATA_W bits each. It oversamples SCLK/nCS/COPI in the system clock domain. Writes commit atomically on nCS rising edge, and only for exact-length frames. Read frames return the addressed register on CIPO. Register contents feed the output-enable, PWM-enable and duty-cycle logic as a flat bus.

Parameters:
NUM_REGS, 8, number of implemented registers (addresses 0..NUM_REGS-1)
DATA_W, 8, register and data-field width in bits
ADDR_W, 7, address-field width; must satisfy 2**ADDR_W >= NUM_REGS
SYNC_STAGES, 2, synchroniser depth on SCLK, nCS and COPI (>=2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
SCLK  in  1  SPI clock, idle low (CPOL=0)
nCS  in  1  chip select, active-low
COPI  in  1  controller-out data, MSB first
CIPO  out  1  target-out data, MSB first
cipo_oe  out  1  high while CIPO is actively driven (read data phase)
regs_flat  out  NUM_REGS*DATA_W  register r occupies bits [r*DATA_W +: DATA_W]
wr_valid  out  1  one-cycle pulse on committed write
wr_addr  out  ADDR_W  address of the last committed write
frame_err  out  1  one-cycle pulse: frame length != FRAME_W
addr_err  out  1  one-cycle pulse: address >= NUM_REGS in a correctly sized frame

Behaviour:
- FRAME_W = 1 + ADDR_W + DATA_W. Frame layout, MSB first: R/W bit (1 = write), address, data.
- Reset (rst=1 at a clk edge): all regs 0; CIPO=0; cipo_oe=0; wr_valid/frame_err/addr_err=0; wr_addr=0. Sync flops clear: SCLK and COPI to 0, nCS to 1, so no false edge appears after reset. Bit counter=0, frame_active=0.
- Each input passes through SYNC_STAGES flops plus one history flop. Edges are detected on the synchronised value. Input to detected edge is SYNC_STAGES+1 clk.
- Supported SCLK frequency: up to clk/8.
- States:
  - IDLE: wait for nCS fall. On fall: counter=0, shift reg cleared, frame_active=1, go to ADDR.
  - ADDR: on each SCLK rise, shift in COPI and increment the counter. When counter reaches 1+ADDR_W:
    - Latch R/W and address.
    - Read with address < NUM_REGS: snapshot that register into the tx shift reg.
    - Read with address out of range: snapshot 0.
    - Go to DATA.
  - DATA: on each SCLK rise, shift in COPI and increment the counter.
    - For reads, the MSB is driven on the first SCLK fall after entering DATA, and one further bit per subsequent SCLK fall.
    - cipo_oe=1 from that first fall until nCS rise.
  - The counter saturates at FRAME_W+1 to mark over-length frames.
- nCS rise while frame_active:
  - Counter != FRAME_W: frame_err=1 for one clk; nothing commits.
  - Write, counter == FRAME_W, address < NUM_REGS: on the next clk edge the register takes the data field, wr_valid=1 and wr_addr=address. The new value is visible on regs_flat on that same edge.
  - Write, counter == FRAME_W, address out of range: addr_err=1 for one clk; regs unchanged.
  - Read, counter == FRAME_W, address out of range: addr_err=1 for one clk.
  - Always, in the same clk: CIPO=0, cipo_oe=0, frame_active=0, go to IDLE.
- SCLK edges while nCS is high are ignored.
- SCLK rise and nCS rise detected in the same clk: the shift is ignored and the frame is evaluated on the pre-edge count.
- Reads never modify registers. Only one write commits per frame.
- rst asserted mid-frame: the frame is abandoned. The later nCS rise sees frame_active=0, so there is no commit and no error pulse.
- nCS fall while frame_active (glitch without a detected rise): restart the frame and discard partial data.

Test Plan:
- Defaults; write frame 0x84A5 (W, addr 0x04, data 0xA5) → regs_flat[39:32]=0xA5; wr_valid pulses once with wr_addr=0x04; other regs stay 0.
- After the write above, read frame 0x0400 → CIPO shifts 1010_0101 on the 8 data-phase SCLK rises; cipo_oe=1 only during the data phase; regs unchanged.
- Write frame 0x8155 truncated to 15 bits, then nCS rise → frame_err pulses; regs[15:8] stays 0. Repeat with 17 bits → frame_err; no write.
- Write 0x9033 (addr 0x10 ≥ NUM_REGS) → addr_err pulses; no wr_valid; all regs unchanged. Read addr 0x10 → CIPO all 0.
- Assert rst after 9 bits of 0x83FF, release, then finish the frame and raise nCS → no commit, no error pulse. A following full 0x83FF frame → regs[31:24]=0xFF.
- Back-to-back writes 0x8011 then 0x8122 with 2 clk of nCS high between them → reg0=0x11, reg1=0x22; two wr_valid pulses.

Source files
------------

// File: rtl/spi_regfile_peripheral_if.sv
// SPI bus bundle between an external controller (master) and the register-file target (slave).
interface spi_regfile_peripheral_if;
    logic SCLK;
    logic nCS;
    logic COPI;
    logic CIPO;
    logic cipo_oe;

    modport master (output SCLK, output nCS, output COPI, input CIPO, input cipo_oe);
    modport slave  (input SCLK, input nCS, input COPI, output CIPO, output cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI Mode-0 target exposing NUM_REGS x DATA_W registers; SPI pins are oversampled in the clk domain.
// Writes commit on nCS rise for exact-length frames only; reads shift the addressed register out on CIPO.
module spi_regfile_peripheral #(
    parameter int NUM_REGS    = 8,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    spi_regfile_peripheral_if.slave      spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_valid,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err,
    output logic                         addr_err
);

    localparam int HDR_W   = 1 + ADDR_W;
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int AW1     = ADDR_W + 1;
    localparam int FL_W    = $clog2(SYNC_STAGES + 1);

    localparam logic [CNT_W-1:0] CNT_HDR   = CNT_W'(HDR_W);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W + 1);
    localparam logic [AW1-1:0]   NUM_REGS_A = AW1'(NUM_REGS);
    localparam logic [FL_W-1:0]  FL_DONE   = FL_W'(SYNC_STAGES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic                   r_sclk_hist;
    logic                   r_ncs_hist;
    logic [FL_W-1:0]        r_flush_cnt;
    logic                   r_armed;

    logic w_sclk_s;
    logic w_ncs_s;
    logic w_copi_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ncs_rise;
    logic w_ncs_fall;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [FRAME_W-1:0] r_shift, w_shift_nxt, w_shift_in;
    logic               r_rw, w_rw_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt, w_hdr_addr;
    logic [DATA_W-1:0]  r_tx, w_tx_nxt, w_rd_data;
    logic               r_cipo, w_cipo_nxt;
    logic               r_oe, w_oe_nxt;
    logic               r_active, w_active_nxt;
    logic               w_addr_ok;
    logic               w_commit;
    logic               w_frame_err_nxt;
    logic               w_addr_err_nxt;

    logic [DATA_W-1:0]  r_regs [NUM_REGS];

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_hist;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_hist;

    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_shift_in = {r_shift[FRAME_W-2:0], w_copi_s};
    assign w_hdr_addr = w_shift_in[ADDR_W-1:0];
    assign w_addr_ok  = ({1'b0, r_addr} < NUM_REGS_A);

    // Input synchronisers plus one history flop; reset values chosen to match the idle bus
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_ncs_sync  <= '1;
            r_copi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_ncs_hist  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], spi.nCS};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.COPI};
            r_sclk_hist <= w_sclk_s;
            r_ncs_hist  <= w_ncs_s;
        end
    end

    // A frame already in progress when reset is released must not look like a new nCS fall:
    // frame starts are accepted only after the synchroniser has flushed and shown nCS high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_flush_cnt <= (r_flush_cnt != FL_DONE) ? r_flush_cnt + FL_W'(1) : r_flush_cnt;
            r_armed     <= r_armed | ((r_flush_cnt == FL_DONE) & w_ncs_s);
        end
    end

    // Read snapshot source; addresses with no implemented register return zero
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_rd_data = (w_hdr_addr == ADDR_W'(i)) ? r_regs[i] : w_rd_data;
        end
    end

    // Next-state and datapath control; nCS rise outranks a coincident SCLK edge
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_rw_nxt        = r_rw;
        w_addr_nxt      = r_addr;
        w_tx_nxt        = r_tx;
        w_cipo_nxt      = r_cipo;
        w_oe_nxt        = r_oe;
        w_active_nxt    = r_active;
        w_commit        = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_addr_err_nxt  = 1'b0;

        if (w_ncs_rise) begin
            if (!r_active) begin
                w_commit = 1'b0;
            end else if (r_cnt != CNT_FRAME) begin
                w_frame_err_nxt = 1'b1;
            end else if (!w_addr_ok) begin
                w_addr_err_nxt = 1'b1;
            end else begin
                w_commit = r_shift[FRAME_W-1];
            end
            w_cipo_nxt   = 1'b0;
            w_oe_nxt     = 1'b0;
            w_active_nxt = 1'b0;
            w_state_nxt  = ST_IDLE;
        end else if (w_ncs_fall && r_armed) begin
            w_cnt_nxt    = '0;
            w_shift_nxt  = '0;
            w_cipo_nxt   = 1'b0;
            w_oe_nxt     = 1'b0;
            w_active_nxt = 1'b1;
            w_state_nxt  = ST_ADDR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_ADDR: begin
                    if (w_sclk_rise) begin
                        w_shift_nxt = w_shift_in;
                        w_cnt_nxt   = w_cnt_inc;
                        if (w_cnt_inc == CNT_HDR) begin
                            w_rw_nxt    = w_shift_in[ADDR_W];
                            w_addr_nxt  = w_hdr_addr;
                            w_tx_nxt    = w_shift_in[ADDR_W] ? '0 : w_rd_data;
                            w_state_nxt = ST_DATA;
                        end else begin
                            w_state_nxt = ST_ADDR;
                        end
                    end else begin
                        w_state_nxt = ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (w_sclk_rise) begin
                        w_shift_nxt = w_shift_in;
                        w_cnt_nxt   = (r_cnt == CNT_SAT) ? r_cnt : w_cnt_inc;
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                    if (w_sclk_fall && !r_rw) begin
                        w_cipo_nxt = r_tx[DATA_W-1];
                        w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
                        w_oe_nxt   = 1'b1;
                    end else begin
                        w_oe_nxt = r_oe;
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_active_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state and frame datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_tx     <= '0;
            r_cipo   <= 1'b0;
            r_oe     <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_rw     <= w_rw_nxt;
            r_addr   <= w_addr_nxt;
            r_tx     <= w_tx_nxt;
            r_cipo   <= w_cipo_nxt;
            r_oe     <= w_oe_nxt;
            r_active <= w_active_nxt;
        end
    end

    // Register bank plus the one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && (r_addr == ADDR_W'(i))) begin
                    r_regs[i] <= r_shift[DATA_W-1:0];
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
            wr_valid  <= w_commit;
            wr_addr   <= w_commit ? r_addr : wr_addr;
            frame_err <= w_frame_err_nxt;
            addr_err  <= w_addr_err_nxt;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign spi.CIPO    = r_cipo;
    assign spi.cipo_oe = r_oe;

endmodule
